rs_multi_cdb: RTL and testbench
===============================

Name: rs_multi_cdb

Overview:
- Parametrised successor to the single-ALU reservation station in the out-of-order core.
- Configurable entry count, ROB tag width and op width.
- Wakes operands from NUM_CDB parallel result buses (ALU, LSB, future units).
- Issue uses a valid/ready handshake with hold-until-accepted semantics, so a stalling execution unit is supported; the station also supports a global flush on mispredict.
- Sits between decoder/dispatch and one execution unit.

Parameters:
- DEPTH, 8, number of entries; power of two, 2..32.
- ROB_W, 4, ROB tag width.
- OP_W, 5, width of operation-type field.
- NUM_CDB, 2, number of result broadcast channels; 1..4.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; when 0, all state is frozen.
- flush  in  1  synchronous clear of all entries (mispredict).
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  entry available (count < DEPTH).
- disp_op  in  OP_W  operation type.
- disp_rob_id  in  ROB_W  destination ROB tag.
- disp_vj, disp_vk  in  32  operand values, used when no dependency.
- disp_has_qj, disp_has_qk  in  1  operand awaits a producer.
- disp_qj, disp_qk  in  ROB_W  producer tags.
- cdb_valid  in  NUM_CDB  per-channel broadcast valid.
- cdb_rob_id  in  NUM_CDB*ROB_W  packed tags; channel c at [c*ROB_W +: ROB_W].
- cdb_value  in  NUM_CDB*32  packed results.
- iss_valid  out  1  entry offered to the execution unit.
- iss_ready  in  1  execution unit accepts.
- iss_op  out  OP_W  operation type of the offered entry.
- iss_rob_id  out  ROB_W  ROB tag of the offered entry.
- iss_vj, iss_vk  out  32  operand values of the offered entry.
- rs_count  out  $clog2(DEPTH)+1  occupied entries.
- rs_full  out  1  rs_count == DEPTH.

Behaviour:
- Reset (rst=0, asynchronous):
  - All busy, has_q and lock state clear; count=0.
  - Outputs: disp_ready=1, iss_valid=0, iss_* data=0, rs_count=0, rs_full=0.
- Dispatch:
  - Fires when rdy & disp_valid & disp_ready & !flush.
  - Writes the lowest-index free entry.
  - disp_ready ignores a same-cycle issue freeing an entry: full stays full for that cycle.
- Dispatch-time capture:
  - If disp_has_qj and any cdb_valid[c] with cdb_rob_id[c]==disp_qj, store that value and clear has_qj. Same rule for qk.
- Wakeup:
  - Every busy entry with has_qj and a matching valid channel captures the value and clears has_qj. Same rule for qk.
  - Multiple matching channels: lowest channel index wins.
- Ready and issue timing:
  - An entry is ready when busy & !has_qj & !has_qk, using registered state only.
  - Minimum latency: broadcast in cycle N, earliest iss_valid in cycle N+1. Dispatch with no dependencies in cycle N, iss_valid in N+1.
- Select: lowest-index ready entry (see Optional Feature).
- Hold:
  - iss_valid is combinational from registered state and forced to 0 when rdy=0.
  - Once iss_valid=1 and iss_ready=0, the offered entry is locked. Selection and iss_* stay stable until acceptance or flush, even if another entry becomes ready.
- Accept:
  - Fires when rdy & iss_valid & iss_ready. The offered entry's busy clears next edge and the lock releases.
  - count changes as +1 (dispatch) / -1 (accept) / 0 (both or neither).
- Flush:
  - On the next edge, clears all busy, has_q and lock state; count=0.
  - Overrides dispatch, wakeup and accept in the same cycle.
  - iss_valid stays combinational and may be 1 in the flush cycle. An accept in that cycle is discarded by the execution unit via its own flush.
- rdy=0: no state changes; CDB inputs are ignored.

Optional Feature:
- Macro: RS_AGE_SELECT_EN.
- Defined:
  - Maintain a DEPTH x DEPTH age matrix, updated on dispatch; freed rows are cleared on accept and flush.
  - Select the oldest ready entry instead of the lowest-index one. Hold/lock rules are unchanged.
- Undefined: lowest-index select, no age storage.

Test Plan:
- Reset then dispatch op=3, rob=5, vj=0x11, vk=0x22, no deps -> iss_valid=1 next cycle with iss_rob_id=5, vj=0x11, vk=0x22; accept -> rs_count returns to 0.
- Dispatch rob=2 with qj=7 pending. Next cycle cdb_valid[1]=1, cdb_rob_id[1]=7, value=0xDEAD -> iss_valid the following cycle with iss_vj=0xDEAD.
- Dispatch qj=4 in the same cycle that channel 0 broadcasts tag 4, value 0x5 -> entry captures 0x5; iss_valid next cycle.
- Fill 8 entries -> rs_full=1, disp_ready=0. Hold iss_ready=0 for 3 cycles -> iss_rob_id constant. Accept -> disp_ready=1 the cycle after.
- With an entry offered, assert flush together with disp_valid -> next cycle rs_count=0, iss_valid=0, and the dispatch is dropped.
- RS_AGE_SELECT_EN: dispatch rob 1 into entry 0 and rob 2 into entry 1, both waiting. Issue and accept rob 1, then dispatch rob 3 (no deps) into entry 0. Wake rob 2 -> oldest-first issues rob 2 before rob 3; with the macro undefined, rob 3 (entry 0) issues first.

Source files
------------

// File: rtl/rs_multi_cdb.sv
// Reservation station with NUM_CDB wakeup buses, lowest-free dispatch and a hold-until-accepted issue port.
// Build with RS_AGE_SELECT_EN defined to select the oldest ready entry instead of the lowest-index one.
module rs_multi_cdb #(
  parameter int DEPTH   = 8,
  parameter int ROB_W   = 4,
  parameter int OP_W    = 5,
  parameter int NUM_CDB = 2,
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int CNT_W  = IDX_W + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [OP_W-1:0]          disp_op,
  input  logic [ROB_W-1:0]         disp_rob_id,
  input  logic [31:0]              disp_vj,
  input  logic [31:0]              disp_vk,
  input  logic                     disp_has_qj,
  input  logic                     disp_has_qk,
  input  logic [ROB_W-1:0]         disp_qj,
  input  logic [ROB_W-1:0]         disp_qk,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0] cdb_rob_id,
  input  logic [NUM_CDB*32-1:0]    cdb_value,
  output logic                     iss_valid,
  input  logic                     iss_ready,
  output logic [OP_W-1:0]          iss_op,
  output logic [ROB_W-1:0]         iss_rob_id,
  output logic [31:0]              iss_vj,
  output logic [31:0]              iss_vk,
  output logic [CNT_W-1:0]         rs_count,
  output logic                     rs_full
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0] busy, has_qj, has_qk, ready;
  logic [OP_W-1:0]  op_q  [DEPTH];
  logic [ROB_W-1:0] rob_q [DEPTH];
  logic [ROB_W-1:0] qj_q  [DEPTH];
  logic [ROB_W-1:0] qk_q  [DEPTH];
  logic [31:0]      vj_q  [DEPTH];
  logic [31:0]      vk_q  [DEPTH];
  logic             lock_vld;
  logic [IDX_W-1:0] lock_idx;
  logic [CNT_W-1:0] count;

  logic [IDX_W-1:0] free_idx, pick_idx, sel;
  logic             pick_found, disp_fire, accept;
  logic [32:0]      wj_hit [DEPTH];
  logic [32:0]      wk_hit [DEPTH];
  logic [32:0]      dj_hit, dk_hit;

  // Returns {hit, value}; the lowest matching channel overrides higher ones.
  function automatic logic [32:0] cdb_match(input logic [ROB_W-1:0] tag,
                                            input logic [NUM_CDB-1:0] v,
                                            input logic [NUM_CDB*ROB_W-1:0] ids,
                                            input logic [NUM_CDB*32-1:0] vals);
    logic [32:0] r;
    r = '0;
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (v[c] && ids[c*ROB_W +: ROB_W] == tag) r = {1'b1, vals[c*32 +: 32]};
    end
    return r;
  endfunction

  assign ready      = busy & ~has_qj & ~has_qk;
  assign disp_ready = (count < FULL_CNT);
  assign rs_count   = count;
  assign rs_full    = (count == FULL_CNT);

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IDX_W'(i);
    end
    dj_hit = cdb_match(disp_qj, cdb_valid, cdb_rob_id, cdb_value);
    dk_hit = cdb_match(disp_qk, cdb_valid, cdb_rob_id, cdb_value);
    for (int i = 0; i < DEPTH; i++) begin
      wj_hit[i] = cdb_match(qj_q[i], cdb_valid, cdb_rob_id, cdb_value);
      wk_hit[i] = cdb_match(qk_q[i], cdb_valid, cdb_rob_id, cdb_value);
    end
  end

`ifdef RS_AGE_SELECT_EN
  // age[i][j] set means entry i was dispatched before entry j.
  logic [DEPTH-1:0] age [DEPTH];

  always_comb begin
    logic older;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      older = 1'b0;
      for (int j = 0; j < DEPTH; j++) older = older | (ready[j] & age[j][i]);
      if (ready[i] && !older) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
    end else if (rdy) begin
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) age[i] <= '0;
      end else begin
        if (accept) age[sel] <= '0;
        if (disp_fire) begin
          age[free_idx] <= '0;
          for (int j = 0; j < DEPTH; j++)
            age[j][free_idx] <= busy[j] & !(accept && sel == IDX_W'(j));
        end
      end
    end
  end
`else
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(i);
      end
    end
  end
`endif

  // A locked entry stays ready until accepted, so lock_vld alone keeps the offer alive.
  assign sel        = lock_vld ? lock_idx : pick_idx;
  assign iss_valid  = rdy & (lock_vld | pick_found);
  assign accept     = iss_valid & iss_ready;
  assign disp_fire  = rdy & disp_valid & disp_ready & !flush;
  assign iss_op     = iss_valid ? op_q[sel]  : '0;
  assign iss_rob_id = iss_valid ? rob_q[sel] : '0;
  assign iss_vj     = iss_valid ? vj_q[sel]  : '0;
  assign iss_vk     = iss_valid ? vk_q[sel]  : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= '0;
      has_qj   <= '0;
      has_qk   <= '0;
      lock_vld <= 1'b0;
      lock_idx <= '0;
      count    <= '0;
    end else if (rdy) begin
      if (flush) begin
        busy     <= '0;
        has_qj   <= '0;
        has_qk   <= '0;
        lock_vld <= 1'b0;
        count    <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (busy[i] && has_qj[i] && wj_hit[i][32]) has_qj[i] <= 1'b0;
          if (busy[i] && has_qk[i] && wk_hit[i][32]) has_qk[i] <= 1'b0;
        end
        if (accept) begin
          busy[sel] <= 1'b0;
          lock_vld  <= 1'b0;
        end else if (iss_valid) begin
          lock_vld  <= 1'b1;
          lock_idx  <= sel;
        end
        if (disp_fire) begin
          busy[free_idx]   <= 1'b1;
          has_qj[free_idx] <= disp_has_qj & !dj_hit[32];
          has_qk[free_idx] <= disp_has_qk & !dk_hit[32];
        end
        case ({disp_fire, accept})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Payload needs no reset: it is only observed while its entry is busy.
  always_ff @(posedge clk) begin
    if (rdy && !flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i] && has_qj[i] && wj_hit[i][32]) vj_q[i] <= wj_hit[i][31:0];
        if (busy[i] && has_qk[i] && wk_hit[i][32]) vk_q[i] <= wk_hit[i][31:0];
      end
      if (disp_fire) begin
        op_q[free_idx]  <= disp_op;
        rob_q[free_idx] <= disp_rob_id;
        qj_q[free_idx]  <= disp_qj;
        qk_q[free_idx]  <= disp_qk;
        vj_q[free_idx]  <= (disp_has_qj && dj_hit[32]) ? dj_hit[31:0] : disp_vj;
        vk_q[free_idx]  <= (disp_has_qk && dk_hit[32]) ? dk_hit[31:0] : disp_vk;
      end
    end
  end

endmodule

// File: tb/tb_rs_multi_cdb.sv
// Bench for rs_multi_cdb: directed scenarios then random traffic against a slot-level reference model.
// Accepted issues are queued by the model and checked by an independent monitor.
module tb_rs_multi_cdb;
  localparam int DEPTH   = 8;
  localparam int ROB_W   = 4;
  localparam int OP_W    = 5;
  localparam int NUM_CDB = 2;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst, rdy, flush, disp_valid, disp_ready, disp_has_qj, disp_has_qk;
  logic [OP_W-1:0] disp_op, iss_op;
  logic [ROB_W-1:0] disp_rob_id, disp_qj, disp_qk, iss_rob_id;
  logic [31:0] disp_vj, disp_vk, iss_vj, iss_vk;
  logic [NUM_CDB-1:0] cdb_valid;
  logic [NUM_CDB*ROB_W-1:0] cdb_rob_id;
  logic [NUM_CDB*32-1:0] cdb_value;
  logic iss_valid, iss_ready, rs_full;
  logic [CNT_W-1:0] rs_count;

  always #5 clk = ~clk;

  rs_multi_cdb #(.DEPTH(DEPTH), .ROB_W(ROB_W), .OP_W(OP_W), .NUM_CDB(NUM_CDB)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_rob_id(disp_rob_id), .disp_vj(disp_vj), .disp_vk(disp_vk),
    .disp_has_qj(disp_has_qj), .disp_has_qk(disp_has_qk),
    .disp_qj(disp_qj), .disp_qk(disp_qk),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
    .iss_rob_id(iss_rob_id), .iss_vj(iss_vj), .iss_vk(iss_vk),
    .rs_count(rs_count), .rs_full(rs_full)
  );

  typedef struct {
    bit busy; bit wj; bit wk; int seq;
    logic [ROB_W-1:0] qj; logic [ROB_W-1:0] qk; logic [ROB_W-1:0] rob;
    logic [31:0] vj; logic [31:0] vk; logic [OP_W-1:0] op;
  } ent_t;
  typedef struct {
    logic [OP_W-1:0] op; logic [ROB_W-1:0] rob; logic [31:0] vj; logic [31:0] vk;
  } iss_t;

  ent_t m [DEPTH];
  int   m_lock = -1;
  int   m_seq  = 0;
  iss_t exp_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit cdb_hit(input logic [ROB_W-1:0] tag, output logic [31:0] val);
    val = '0;
    for (int c = 0; c < NUM_CDB; c++) begin
      if (cdb_valid[c] && cdb_rob_id[c*ROB_W +: ROB_W] == tag) begin
        val = cdb_value[c*32 +: 32];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // Checks this cycle's outputs, then advances the model to the state after the coming edge.
  task automatic model_step();
    int off, cnt, f;
    ent_t nx [DEPTH];
    logic [31:0] v;
    iss_t e;
    cnt = 0;
    foreach (m[i]) if (m[i].busy) cnt++;
    off = -1;
    if (rdy) begin
      if (m_lock >= 0) off = m_lock;
      else begin
        foreach (m[i]) begin
          if (m[i].busy && !m[i].wj && !m[i].wk) begin
`ifdef RS_AGE_SELECT_EN
            if (off < 0 || m[i].seq < m[off].seq) off = i;
`else
            if (off < 0) off = i;
`endif
          end
        end
      end
    end
    chk("iss_valid", 64'(iss_valid), 64'(off >= 0));
    chk("rs_count", 64'(rs_count), 64'(cnt));
    chk("rs_full", 64'(rs_full), 64'(cnt == DEPTH));
    chk("disp_ready", 64'(disp_ready), 64'(cnt < DEPTH));
    if (off >= 0 && iss_ready) begin
      e.op = m[off].op; e.rob = m[off].rob; e.vj = m[off].vj; e.vk = m[off].vk;
      exp_q.push_back(e);
    end
    if (!rdy) return;
    if (flush) begin
      foreach (m[i]) begin m[i].busy = 0; m[i].wj = 0; m[i].wk = 0; end
      m_lock = -1;
      return;
    end
    nx = m;
    foreach (m[i]) begin
      if (m[i].busy && m[i].wj && cdb_hit(m[i].qj, v)) begin nx[i].wj = 0; nx[i].vj = v; end
      if (m[i].busy && m[i].wk && cdb_hit(m[i].qk, v)) begin nx[i].wk = 0; nx[i].vk = v; end
    end
    if (off >= 0) begin
      if (iss_ready) begin nx[off].busy = 0; m_lock = -1; end
      else m_lock = off;
    end
    if (disp_valid && cnt < DEPTH) begin
      f = -1;
      foreach (m[i]) if (!m[i].busy && f < 0) f = i;
      nx[f].busy = 1; nx[f].op = disp_op; nx[f].rob = disp_rob_id;
      nx[f].qj = disp_qj; nx[f].qk = disp_qk; nx[f].vj = disp_vj; nx[f].vk = disp_vk;
      nx[f].wj = disp_has_qj; nx[f].wk = disp_has_qk; nx[f].seq = m_seq++;
      if (disp_has_qj && cdb_hit(disp_qj, v)) begin nx[f].wj = 0; nx[f].vj = v; end
      if (disp_has_qk && cdb_hit(disp_qk, v)) begin nx[f].wk = 0; nx[f].vk = v; end
    end
    m = nx;
  endtask

  task automatic step();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [OP_W-1:0] op, input logic [ROB_W-1:0] rob,
                      input logic [31:0] vj, input logic [31:0] vk,
                      input logic hj, input logic [ROB_W-1:0] qj,
                      input logic hk, input logic [ROB_W-1:0] qk);
    disp_valid = 1; disp_op = op; disp_rob_id = rob; disp_vj = vj; disp_vk = vk;
    disp_has_qj = hj; disp_qj = qj; disp_has_qk = hk; disp_qk = qk;
  endtask

  initial begin
    iss_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst && iss_valid && iss_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL issue_unexpected: got rob 0x%0h expected no issue", iss_rob_id);
        end else begin
          e = exp_q.pop_front();
          chk("iss_op", 64'(iss_op), 64'(e.op));
          chk("iss_rob_id", 64'(iss_rob_id), 64'(e.rob));
          chk("iss_vj", 64'(iss_vj), 64'(e.vj));
          chk("iss_vk", 64'(iss_vk), 64'(e.vk));
        end
      end
    end
  end

  initial begin
    rst = 0; rdy = 1; flush = 0; disp_valid = 0; iss_ready = 0;
    disp_op = '0; disp_rob_id = '0; disp_vj = '0; disp_vk = '0;
    disp_has_qj = 0; disp_has_qk = 0; disp_qj = '0; disp_qk = '0;
    cdb_valid = '0; cdb_rob_id = '0; cdb_value = '0;
    #12;
    chk("reset_iss_valid", 64'(iss_valid), 0);
    chk("reset_disp_ready", 64'(disp_ready), 1);
    chk("reset_rs_count", 64'(rs_count), 0);
    chk("reset_rs_full", 64'(rs_full), 0);
    chk("reset_iss_rob_id", 64'(iss_rob_id), 0);
    chk("reset_iss_vj", 64'(iss_vj), 0);
    @(posedge clk); #1;
    rst = 1;

    // Dependency-free dispatch issues the next cycle.
    disp(5'd3, 4'd5, 32'h11, 32'h22, 0, 4'd0, 0, 4'd0);
    step();
    disp_valid = 0;
    chk("t1_valid", 64'(iss_valid), 1);
    chk("t1_rob", 64'(iss_rob_id), 5);
    chk("t1_vj", 64'(iss_vj), 64'h11);
    chk("t1_vk", 64'(iss_vk), 64'h22);
    iss_ready = 1; step(); iss_ready = 0;
    chk("t1_count", 64'(rs_count), 0);

    // Wakeup from channel 1.
    disp(5'd1, 4'd2, 32'h0, 32'h22, 1, 4'd7, 0, 4'd0);
    step();
    disp_valid = 0;
    cdb_valid = 2'b10; cdb_rob_id = {4'd7, 4'd0}; cdb_value = {32'hDEAD, 32'h0};
    step();
    cdb_valid = '0;
    chk("t2_valid", 64'(iss_valid), 1);
    chk("t2_vj", 64'(iss_vj), 64'hDEAD);
    iss_ready = 1; step(); iss_ready = 0;

    // Capture at dispatch from channel 0.
    disp(5'd2, 4'd6, 32'h0, 32'h33, 1, 4'd4, 0, 4'd0);
    cdb_valid = 2'b01; cdb_rob_id = {4'd0, 4'd4}; cdb_value = {32'h0, 32'h5};
    step();
    disp_valid = 0; cdb_valid = '0;
    chk("t3_valid", 64'(iss_valid), 1);
    chk("t3_vj", 64'(iss_vj), 64'h5);
    iss_ready = 1; step(); iss_ready = 0;

    // Fill, hold under stall, then accept.
    for (int i = 0; i < DEPTH; i++) begin
      disp(5'(i), 4'(i), 32'(i), 32'(i + 100), 0, 4'd0, 0, 4'd0);
      step();
    end
    disp_valid = 0;
    chk("t4_full", 64'(rs_full), 1);
    chk("t4_disp_ready", 64'(disp_ready), 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t4_hold_rob", 64'(iss_rob_id), 0);
    end
    iss_ready = 1; step(); iss_ready = 0;
    chk("t4_ready_after", 64'(disp_ready), 1);
    chk("t4_count_after", 64'(rs_count), DEPTH - 1);
    iss_ready = 1;
    repeat (DEPTH - 1) step();
    iss_ready = 0;
    chk("t4_drained", 64'(rs_count), 0);

    // Flush with a concurrent dispatch.
    disp(5'd4, 4'd9, 32'h1, 32'h2, 0, 4'd0, 0, 4'd0);
    step();
    chk("t5_offered", 64'(iss_valid), 1);
    flush = 1;
    disp(5'd4, 4'd10, 32'h3, 32'h4, 0, 4'd0, 0, 4'd0);
    step();
    flush = 0; disp_valid = 0;
    chk("t5_count", 64'(rs_count), 0);
    chk("t5_valid", 64'(iss_valid), 0);
    step();
    chk("t5_dropped", 64'(rs_count), 0);

    // Age-versus-index ordering.
    disp(5'd0, 4'd1, 32'h0, 32'h0, 1, 4'd9, 0, 4'd0);
    step();
    disp(5'd0, 4'd2, 32'h0, 32'h0, 1, 4'd10, 0, 4'd0);
    step();
    disp_valid = 0;
    cdb_valid = 2'b01; cdb_rob_id = {4'd0, 4'd9}; cdb_value = {32'h0, 32'h66};
    step();
    cdb_valid = '0;
    chk("t6_rob1", 64'(iss_rob_id), 1);
    iss_ready = 1; step(); iss_ready = 0;
    disp(5'd0, 4'd3, 32'h0, 32'h0, 0, 4'd0, 0, 4'd0);
    cdb_valid = 2'b01; cdb_rob_id = {4'd0, 4'd10}; cdb_value = {32'h0, 32'h77};
    step();
    disp_valid = 0; cdb_valid = '0;
    chk("t6_valid", 64'(iss_valid), 1);
`ifdef RS_AGE_SELECT_EN
    chk("t6_first", 64'(iss_rob_id), 2);
`else
    chk("t6_first", 64'(iss_rob_id), 3);
`endif
    iss_ready = 1; step();
`ifdef RS_AGE_SELECT_EN
    chk("t6_second", 64'(iss_rob_id), 3);
`else
    chk("t6_second", 64'(iss_rob_id), 2);
`endif
    step(); iss_ready = 0;
    chk("t6_empty", 64'(rs_count), 0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      rdy         = ($urandom_range(0, 9) != 0);
      flush       = ($urandom_range(0, 59) == 0);
      disp_valid  = $urandom_range(0, 1);
      disp_op     = OP_W'($urandom);
      disp_rob_id = ROB_W'($urandom);
      disp_vj     = $urandom;
      disp_vk     = $urandom;
      disp_has_qj = ($urandom_range(0, 2) == 0);
      disp_has_qk = ($urandom_range(0, 2) == 0);
      disp_qj     = ROB_W'($urandom_range(0, 7));
      disp_qk     = ROB_W'($urandom_range(0, 7));
      cdb_valid   = NUM_CDB'($urandom);
      cdb_rob_id  = {ROB_W'($urandom_range(0, 7)), ROB_W'($urandom_range(0, 7))};
      cdb_value   = {$urandom, $urandom};
      iss_ready   = ($urandom_range(0, 2) != 0);
      step();
    end
    rdy = 1; disp_valid = 0; cdb_valid = '0; iss_ready = 0; flush = 1;
    step();
    flush = 0;
    step();
    chk("end_queue_empty", 64'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
